// File: rtl/simd_mac_fu.sv
// simd_mac_fu: pipelined packed 8/16-bit dot-product MAC into NUM_ACC accumulators.
// Stage 1 registers the dot product; accumulators are read and written only by the last stage.
module simd_mac_fu #(
    parameter int XLEN          = 32,
    parameter int NUM_ACC       = 4,
    parameter int ACC_W         = 32,
    parameter int PIPE_STAGES   = 2,
    parameter int TRANS_ID_BITS = 3
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [1:0]               op_i,
    input  logic                     elem16_i,
    input  logic                     signed_i,
    input  logic                     sat_i,
    input  logic [2:0]               acc_sel_i,
    input  logic [XLEN-1:0]          operand_a_i,
    input  logic [XLEN-1:0]          operand_b_i,
    input  logic [TRANS_ID_BITS-1:0] trans_id_i,
    output logic [XLEN-1:0]          result_o,
    output logic                     valid_o,
    output logic [TRANS_ID_BITS-1:0] trans_id_o,
    output logic                     exception_o
);
    localparam int DW = 34 + $clog2(XLEN);
    localparam logic [1:0] OP_ACC = 2'd1, OP_READ = 2'd2, OP_CLR = 2'd3;

    typedef struct packed {
        logic [1:0]               op;
        logic                     sat;
        logic [2:0]               sel;
        logic                     ill;
        logic [TRANS_ID_BITS-1:0] tid;
        logic [ACC_W-1:0]         dot;
    } stage_t;

    stage_t                   r_st [PIPE_STAGES];
    logic [PIPE_STAGES-1:0]   r_v;
    logic [ACC_W-1:0]         r_acc [8];
    logic                     r_ready, r_valid, r_exc;
    logic [XLEN-1:0]          r_result;
    logic [TRANS_ID_BITS-1:0] r_tid;

    logic signed [DW-1:0] w_sum8, w_sum16;
    logic [ACC_W-1:0]     w_dot, w_cur, w_base, w_new, w_res;
    logic [ACC_W:0]       w_add;
    logic                 w_accept, w_fire, w_ill;
    stage_t               w_in, w_last;

    // Lanes are extended by one bit (sign or zero) so one signed multiply covers both modes.
    always_comb begin
        w_sum8  = '0;
        w_sum16 = '0;
        for (int k = 0; k < XLEN / 8; k++)
            w_sum8 = w_sum8 + DW'($signed({signed_i & operand_a_i[k*8+7], operand_a_i[k*8+:8]}))
                            * DW'($signed({signed_i & operand_b_i[k*8+7], operand_b_i[k*8+:8]}));
        for (int k = 0; k < XLEN / 16; k++)
            w_sum16 = w_sum16 + DW'($signed({signed_i & operand_a_i[k*16+15], operand_a_i[k*16+:16]}))
                              * DW'($signed({signed_i & operand_b_i[k*16+15], operand_b_i[k*16+:16]}));
    end

    assign w_dot    = ACC_W'(elem16_i ? w_sum16 : w_sum8);
    assign w_ill    = 32'(acc_sel_i) >= NUM_ACC;
    assign w_accept = valid_i & r_ready & ~flush_i;
    assign w_in     = '{op: op_i, sat: sat_i, sel: acc_sel_i, ill: w_ill, tid: trans_id_i, dot: w_dot};

    assign w_last = r_st[PIPE_STAGES-1];
    assign w_fire = r_v[PIPE_STAGES-1] & ~flush_i;
    assign w_cur  = r_acc[w_last.sel];
    assign w_base = (w_last.op == OP_ACC) ? w_cur : '0;
    assign w_add  = {w_base[ACC_W-1], w_base} + {w_last.dot[ACC_W-1], w_last.dot};
    // One extra sum bit exposes signed overflow; clamp toward its sign.
    assign w_new  = (w_last.sat && (w_add[ACC_W] != w_add[ACC_W-1]))
                  ? {w_add[ACC_W], {(ACC_W-1){~w_add[ACC_W]}}} : w_add[ACC_W-1:0];
    assign w_res  = (w_last.ill || w_last.op == OP_CLR) ? '0 : (w_last.op == OP_READ) ? w_cur : w_new;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_v      <= '0;
            for (int k = 0; k < PIPE_STAGES; k++) r_st[k] <= '0;
            for (int k = 0; k < 8; k++) r_acc[k] <= '0;
            r_ready  <= 1'b0;
            r_valid  <= 1'b0;
            r_exc    <= 1'b0;
            r_result <= '0;
            r_tid    <= '0;
        end else begin
            r_ready <= 1'b1;
            r_v     <= flush_i ? '0 : {r_v[PIPE_STAGES-2:0], w_accept};
            r_st[0] <= w_in;
            for (int k = 1; k < PIPE_STAGES; k++) r_st[k] <= r_st[k-1];
            r_valid <= w_fire;
            r_exc   <= w_fire & w_last.ill;
            if (w_fire) begin
                r_result <= w_res[XLEN-1:0];
                r_tid    <= w_last.tid;
            end
            if (w_fire && !w_last.ill && w_last.op != OP_READ) r_acc[w_last.sel] <= w_res;
        end
    end

    assign ready_o     = r_ready;
    assign valid_o     = r_valid;
    assign exception_o = r_exc;
    assign result_o    = r_result;
    assign trans_id_o  = r_tid;
endmodule

// File: tb/tb_simd_mac_fu.sv
// tb_simd_mac_fu: directed and random ops against a lane-arithmetic reference model,
// with expected results queued at issue and retired by an independent monitor.
module tb_simd_mac_fu;
    localparam int P = 2;
    localparam int NACC = 3;
    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -MAXV - 1;

    logic        clk = 0, rst_n = 1, in_flush = 0, in_valid = 0;
    logic [1:0]  in_op = 0;
    logic        in_e16 = 0, in_sgn = 0, in_sat = 0;
    logic [2:0]  in_sel = 0, in_tid = 0;
    logic [31:0] in_a = 0, in_b = 0;
    logic        ready_o, valid_o, exception_o;
    logic [31:0] result_o;
    logic [2:0]  trans_id_o;

    simd_mac_fu #(.XLEN(32), .NUM_ACC(NACC), .ACC_W(32), .PIPE_STAGES(P), .TRANS_ID_BITS(3)) dut (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(in_flush), .valid_i(in_valid), .ready_o(ready_o),
        .op_i(in_op), .elem16_i(in_e16), .signed_i(in_sgn), .sat_i(in_sat), .acc_sel_i(in_sel),
        .operand_a_i(in_a), .operand_b_i(in_b), .trans_id_i(in_tid), .result_o(result_o),
        .valid_o(valid_o), .trans_id_o(trans_id_o), .exception_o(exception_o));

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        logic [2:0]  tid;
        int          due;
        logic        wr;
        logic [2:0]  sel;
        logic [31:0] old;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [31:0] macc [8];
    logic [2:0]  tid_ctr = 0;
    int          cyc = 0, checks = 0, failures = 0;
    localparam logic [31:0] A = 32'h55667788, B = 32'h11223344, M = 32'h7FFF7FFF;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mdot(input logic [31:0] a, input logic [31:0] b, input logic e16, input logic sgn);
        longint s = 0, x, y;
        int w = e16 ? 16 : 8;
        for (int i = 0; i < 32 / w; i++) begin
            x = longint'((a >> (i * w)) & ((32'd1 << w) - 1));
            y = longint'((b >> (i * w)) & ((32'd1 << w) - 1));
            if (sgn && x >= (64'sd1 << (w - 1))) x -= 64'sd1 << w;
            if (sgn && y >= (64'sd1 << (w - 1))) y -= 64'sd1 << w;
            s += x * y;
        end
        return s[31:0];
    endfunction

    task automatic drive(input logic v, input logic fl, input logic [1:0] op, input logic e16, input logic sgn,
                         input logic sat, input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input logic xen = 0, input logic [31:0] xv = 0);
        exp_t e;
        longint t;
        logic [31:0] nv;
        @(negedge clk);
        in_valid = v; in_flush = fl; in_op = op; in_e16 = e16; in_sgn = sgn; in_sat = sat;
        in_sel = sel; in_a = a; in_b = b; in_tid = tid_ctr;
        if (fl) while (q.size() != 0) begin
            e = q.pop_back();
            if (e.wr) macc[e.sel] = e.old;
        end
        if (v && !fl) begin
            t = (op == 2'd1 ? longint'($signed(macc[sel])) : 64'sd0) + longint'($signed(mdot(a, b, e16, sgn)));
            if (sat && t > MAXV) t = MAXV;
            if (sat && t < MINV) t = MINV;
            nv = t[31:0];
            e.sel = sel; e.old = macc[sel]; e.tid = tid_ctr; e.due = cyc + 1 + P;
            e.exc = (sel >= NACC);
            e.wr  = !e.exc && op != 2'd2;
            e.res = e.exc ? 32'd0 : op == 2'd2 ? macc[sel] : op == 2'd3 ? 32'd0 : nv;
            if (xen) e.res = xv;
            if (e.wr) macc[sel] = (op == 2'd3) ? 32'd0 : nv;
            q.push_back(e);
            tid_ctr++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 0;
        in_valid = 0; in_flush = 0;
        q.delete();
        for (int i = 0; i < 8; i++) macc[i] = 0;
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            check("reset_valid", valid_o, 0);
            check("reset_ready", ready_o, 0);
            check("reset_result", result_o, 0);
            check("reset_tid", trans_id_o, 0);
            check("reset_exc", exception_o, 0);
        end else begin
            check("ready", ready_o, 1);
            while (q.size() != 0 && q[0].due < cyc) begin
                checks++; failures++;
                $display("FAIL missing_result: no valid_o for tid %0d, required by cycle %0d", q[0].tid, q[0].due);
                void'(q.pop_front());
            end
            if (valid_o) begin
                if (q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_valid: got result %0h tid %0d, required no output", result_o, trans_id_o);
                end else begin
                    mon_e = q.pop_front();
                    check("result", result_o, mon_e.res);
                    check("exception", exception_o, mon_e.exc);
                    check("trans_id", trans_id_o, mon_e.tid);
                    check("latency_cycle", cyc, mon_e.due);
                end
            end else check("exc_idle", exception_o, 0);
        end
    end

    initial begin
        logic [2:0] rs;
        do_reset();
        drive(1, 0, 0, 0, 0, 0, 0, A, B, 1, 20230);
        drive(1, 0, 1, 0, 0, 0, 0, A, B, 1, 40460);
        drive(1, 0, 0, 0, 1, 0, 0, A, B, 1, 2822);
        drive(1, 0, 0, 1, 0, 0, 0, A, B, 1, 497481132);
        drive(1, 0, 1, 0, 0, 0, 1, A, B, 1, 20230);
        drive(1, 0, 1, 0, 0, 0, 1, A, B, 1, 40460);
        drive(1, 0, 1, 0, 0, 0, 1, A, B, 1, 60690);
        drive(1, 0, 0, 1, 1, 0, 0, M, M, 1, 32'h7FFE0002);
        drive(1, 0, 1, 1, 1, 1, 0, M, M, 1, 32'h7FFFFFFF);
        drive(1, 0, 0, 1, 1, 0, 0, M, M, 1, 32'h7FFE0002);
        drive(1, 0, 1, 1, 1, 0, 0, M, M, 1, 32'hFFFC0004);
        drive(1, 0, 0, 0, 0, 0, 2, A, B, 1, 20230);
        idle(3);
        drive(1, 0, 1, 0, 0, 0, 2, A, B);
        drive(1, 1, 0, 0, 0, 0, 2, M, M);
        idle(1);
        drive(1, 0, 2, 0, 0, 0, 2, 0, 0, 1, 20230);
        idle(3);
        drive(1, 0, 1, 0, 0, 0, 2, A, B);
        idle(1);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 2, 0, 0, 0, 2, 0, 0, 1, 20230);
        drive(1, 0, 0, 0, 0, 0, 5, A, B, 1, 0);
        drive(1, 0, 2, 0, 0, 0, 0, 0, 0, 1, 32'hFFFC0004);
        drive(1, 0, 2, 0, 0, 0, 1, 0, 0, 1, 60690);
        drive(1, 0, 2, 0, 0, 0, 2, 0, 0, 1, 20230);
        drive(1, 0, 0, 0, 0, 0, 0, A, B);
        do_reset();
        drive(1, 0, 2, 0, 0, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 2, 0, 0, 0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 400; i++) begin
            rs = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            drive($urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0, 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rs,
                  $urandom, $urandom);
        end
        idle(1);
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        if (q.size() != 0) begin
            checks++; failures++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
